// File: rtl/data_align_fsm_mc.sv
// data_align_fsm_mc: time-multiplexed IDELAY/bitslip aligner for N_CH ADC lanes.
// Each lane gets a full tap sweep; the centre of the widest matching window is loaded.
module data_align_fsm_mc #(
    parameter int N_CH = 8,
    parameter int DW = 14,
    parameter int TAP_W = 5,
    parameter logic [DW-1:0] PATTERN = 14'h2867,
    parameter int SETTLE = 15,
    parameter int JUDGE_LEN = 1024,
    parameter int MIN_EYE = 3,
    parameter int MAX_SLIP = DW - 1,
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk_ref,
    input  logic                  reset_n,
    input  logic [N_CH*DW-1:0]    data_pattern,
    input  logic                  fco_aligned,
    input  logic                  ad_test_mode,
    input  logic                  start,
    output logic [N_CH-1:0]       idelay_ld,
    output logic [N_CH*TAP_W-1:0] cnt_value,
    output logic [N_CH-1:0]       dat_bitslip,
    output logic [N_CH-1:0]       dat_aligned,
    output logic                  align_busy,
    output logic                  align_done,
    output logic                  align_fail,
    output logic [CHW-1:0]        cur_ch,
    output logic [3:0]            delay_fsm
);

    localparam int CMAX = (SETTLE > JUDGE_LEN) ? SETTLE : JUDGE_LEN;
    localparam int CW = $clog2(CMAX + 1);
    localparam int SW = (MAX_SLIP > 0) ? $clog2(MAX_SLIP + 1) : 1;
    localparam int LW = TAP_W + 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] JUDGE_LAST = CW'(JUDGE_LEN - 1);
    localparam logic [TAP_W-1:0] TAP_MAX = '1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(N_CH - 1);
    localparam logic [LW-1:0] EYE_MIN = LW'(MIN_EYE);
    localparam logic [SW-1:0] SLIP_MAX = SW'(MAX_SLIP);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD      = 4'd1,
        S_SETTLE    = 4'd2,
        S_JUDGE     = 4'd3,
        S_RECORD    = 4'd4,
        S_EVAL      = 4'd5,
        S_SLIP      = 4'd6,
        S_SLIP_WAIT = 4'd7,
        S_CENTER_LD = 4'd8,
        S_NEXT_CH   = 4'd9,
        S_DONE      = 4'd10
    } state_t;

    state_t state_q, state_d;

    logic [CHW-1:0]        cur_ch_q, cur_ch_d;
    logic [TAP_W-1:0]      tap_q, tap_d;
    logic [SW-1:0]         slip_q, slip_d;
    logic [TAP_W-1:0]      run_start_q, run_start_d;
    logic [LW-1:0]         run_len_q, run_len_d;
    logic [TAP_W-1:0]      best_start_q, best_start_d;
    logic [LW-1:0]         best_len_q, best_len_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pass_q, pass_d;
    logic [N_CH*TAP_W-1:0] cntv_q, cntv_d;
    logic [N_CH-1:0]       aligned_q, aligned_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;

    logic [DW-1:0]    lane_data;
    logic             lane_match;
    logic             start_ok;
    logic             abort;
    logic             eye_ok;
    logic             slip_ok;
    logic [LW-1:0]    run_inc;
    logic [TAP_W-1:0] centre;
    logic             clr_win;

    // Pick the data word of the lane under test.
    always_comb begin
        lane_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cur_ch_q == CHW'(c)) begin
                lane_data = data_pattern[c*DW +: DW];
            end
        end
    end

    assign lane_match = (lane_data == PATTERN);
    assign start_ok = start && fco_aligned && ad_test_mode;
    assign abort = busy_q && !(fco_aligned && ad_test_mode);
    assign eye_ok = (best_len_q >= EYE_MIN);
    assign slip_ok = (slip_q < SLIP_MAX);
    assign run_inc = run_len_q + LW'(1);
    // Centre tap of the best window; the sum always fits in TAP_W bits.
    assign centre = best_start_q + TAP_W'((best_len_q - LW'(1)) >> 1);

    // State register.
    always_ff @(posedge clk_ref or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a lost frame or test mode overrides everything.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) state_d = S_LOAD;
                end
                S_LOAD: state_d = S_SETTLE;
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) state_d = S_JUDGE;
                end
                S_JUDGE: begin
                    if (!lane_match || cnt_q == JUDGE_LAST) state_d = S_RECORD;
                end
                S_RECORD: begin
                    state_d = (tap_q == TAP_MAX) ? S_EVAL : S_LOAD;
                end
                S_EVAL: begin
                    if (eye_ok) state_d = S_CENTER_LD;
                    else if (slip_ok) state_d = S_SLIP;
                    else state_d = S_NEXT_CH;
                end
                S_SLIP: state_d = S_SLIP_WAIT;
                S_SLIP_WAIT: begin
                    if (cnt_q == SETTLE_LAST) state_d = S_LOAD;
                end
                S_CENTER_LD: state_d = S_NEXT_CH;
                S_NEXT_CH: begin
                    state_d = (cur_ch_q == LAST_CH) ? S_DONE : S_LOAD;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values: counters, window tracking and status flags.
    always_comb begin
        cur_ch_d = cur_ch_q;
        tap_d = tap_q;
        slip_d = slip_q;
        run_start_d = run_start_q;
        run_len_d = run_len_q;
        best_start_d = best_start_q;
        best_len_d = best_len_q;
        cnt_d = cnt_q;
        pass_d = pass_q;
        cntv_d = cntv_q;
        aligned_d = aligned_q;
        busy_d = busy_q;
        done_d = done_q;
        fail_d = fail_q;
        clr_win = 1'b0;
        if (abort) begin
            busy_d = 1'b0;
            fail_d = 1'b1;
            done_d = 1'b0;
            aligned_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        cur_ch_d = '0;
                        aligned_d = '0;
                        done_d = 1'b0;
                        fail_d = 1'b0;
                        busy_d = 1'b1;
                        tap_d = '0;
                        slip_d = '0;
                        cnt_d = '0;
                        clr_win = 1'b1;
                    end
                end
                S_LOAD: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (cur_ch_q == CHW'(c)) begin
                            cntv_d[c*TAP_W +: TAP_W] = tap_q;
                        end
                    end
                    cnt_d = '0;
                end
                S_SETTLE, S_SLIP_WAIT: begin
                    cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + CW'(1);
                end
                S_JUDGE: begin
                    if (!lane_match) begin
                        pass_d = 1'b0;
                    end else if (cnt_q == JUDGE_LAST) begin
                        pass_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RECORD: begin
                    if (pass_q) begin
                        if (run_len_q == '0) run_start_d = tap_q;
                        run_len_d = run_inc;
                        if (run_inc > best_len_q) begin
                            best_start_d = (run_len_q == '0) ? tap_q : run_start_q;
                            best_len_d = run_inc;
                        end
                    end else begin
                        run_len_d = '0;
                    end
                    if (tap_q != TAP_MAX) tap_d = tap_q + TAP_W'(1);
                end
                S_EVAL: begin
                    if (eye_ok) tap_d = centre;
                    else if (!slip_ok) fail_d = 1'b1;
                end
                S_SLIP: begin
                    slip_d = slip_q + SW'(1);
                    tap_d = '0;
                    cnt_d = '0;
                    clr_win = 1'b1;
                end
                S_CENTER_LD: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (cur_ch_q == CHW'(c)) begin
                            cntv_d[c*TAP_W +: TAP_W] = tap_q;
                            aligned_d[c] = 1'b1;
                        end
                    end
                end
                S_NEXT_CH: begin
                    if (cur_ch_q == LAST_CH) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        cur_ch_d = cur_ch_q + CHW'(1);
                        tap_d = '0;
                        slip_d = '0;
                        clr_win = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (clr_win) begin
            run_start_d = '0;
            run_len_d = '0;
            best_start_d = '0;
            best_len_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_ref or negedge reset_n) begin
        if (!reset_n) begin
            cur_ch_q <= '0;
            tap_q <= '0;
            slip_q <= '0;
            run_start_q <= '0;
            run_len_q <= '0;
            best_start_q <= '0;
            best_len_q <= '0;
            cnt_q <= '0;
            pass_q <= 1'b0;
            cntv_q <= '0;
            aligned_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            cur_ch_q <= cur_ch_d;
            tap_q <= tap_d;
            slip_q <= slip_d;
            run_start_q <= run_start_d;
            run_len_q <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q <= best_len_d;
            cnt_q <= cnt_d;
            pass_q <= pass_d;
            cntv_q <= cntv_d;
            aligned_q <= aligned_d;
            busy_q <= busy_d;
            done_q <= done_d;
            fail_q <= fail_d;
        end
    end

    // Strobes decode from state so only the current lane ever pulses.
    always_comb begin
        idelay_ld = '0;
        dat_bitslip = '0;
        cnt_value = cntv_q;
        for (int c = 0; c < N_CH; c++) begin
            if (cur_ch_q == CHW'(c)) begin
                if (state_q == S_LOAD || state_q == S_CENTER_LD) begin
                    idelay_ld[c] = 1'b1;
                    cnt_value[c*TAP_W +: TAP_W] = tap_q;
                end
                if (state_q == S_SLIP) begin
                    dat_bitslip[c] = 1'b1;
                end
            end
        end
    end

    assign dat_aligned = aligned_q;
    assign align_busy = busy_q;
    assign align_done = done_q;
    assign align_fail = fail_q;
    assign cur_ch = cur_ch_q;
    assign delay_fsm = state_q;

endmodule

// File: doc/data_align_fsm_mc.md
Name: data_align_fsm_mc

Overview:
- Parametrised, multi-channel successor to the single-channel ADC data-alignment FSM. One time-multiplexed controller aligns N_CH serial ADC data lanes in turn, from channel 0 upward.
- For each lane it runs a full IDELAYE2 tap sweep and records the longest contiguous window in which the training pattern matches. It then loads the centre tap of that window.
- If no window meets MIN_EYE, it issues a bitslip and sweeps again.
- It sits between the per-lane ISERDES/IDELAY data modules and the readout control logic.

Parameters:
N_CH, 8, number of data lanes.
DW, 14, deserialised word width.
TAP_W, 5, IDELAY tap-value width; the sweep covers taps 0..2^TAP_W-1.
PATTERN, 14'h2867, test-mode training word.
SETTLE, 15, wait cycles after each tap load or bitslip.
JUDGE_LEN, 1024, consecutive matching cycles required for a tap to pass.
MIN_EYE, 3, minimum window length (in taps) accepted as valid.
MAX_SLIP, DW-1, bitslips allowed per lane before that lane is declared failed.

Ports:
clk_ref  in  1  reference clock; all logic on the rising edge only.
reset_n  in  1  asynchronous, active-low reset.
data_pattern  in  N_CH*DW  lane c at [c*DW +: DW].
fco_aligned  in  1  frame clock aligned.
ad_test_mode  in  1  ADC is emitting PATTERN.
start  in  1  single-cycle request to (re)start alignment.
idelay_ld  out  N_CH  one-cycle load strobe per lane.
cnt_value  out  N_CH*TAP_W  per-lane tap value, lane c at [c*TAP_W +: TAP_W].
dat_bitslip  out  N_CH  one-cycle bitslip pulse per lane.
dat_aligned  out  N_CH  lane aligned and centred.
align_busy  out  1  sweep in progress.
align_done  out  1  all lanes processed.
align_fail  out  1  one or more lanes failed, or the run was aborted.
cur_ch  out  max(1,$clog2(N_CH))  lane currently being processed.
delay_fsm  out  4  binary state code, for debug.

Behaviour:
- Reset values: every output is 0. Internal tap, slip and window registers are 0.
- start is accepted only in IDLE or DONE, and only while fco_aligned and ad_test_mode are both 1. Otherwise it is ignored.
- On acceptance: cur_ch=0, dat_aligned=0, align_done=0, align_fail=0, align_busy=1.

State machine:
- IDLE/DONE --start--> LOAD. Entry clears tap=0, slip_cnt=0 and the window registers.
- LOAD: idelay_ld[cur_ch]=1 for exactly one cycle, with cnt_value[cur_ch]=tap -> SETTLE.
- SETTLE: count SETTLE cycles -> JUDGE.
- JUDGE: compare data_pattern[cur_ch] against PATTERN on every cycle.
  - Any mismatch -> RECORD, tap marked fail.
  - JUDGE_LEN consecutive matches -> RECORD, tap marked pass.
- RECORD, on pass:
  - If run_len==0, set run_start=tap.
  - run_len++.
  - If run_len(new) > best_len, set best_start=run_start and best_len=run_len(new).
- RECORD, on fail: run_len=0.
- RECORD exit: if tap == 2^TAP_W-1 -> EVAL, else tap++ -> LOAD.
- EVAL:
  - best_len >= MIN_EYE: tap = best_start + ((best_len-1)>>1) -> CENTER_LD.
  - Otherwise, slip_cnt < MAX_SLIP: -> SLIP.
  - Otherwise: align_fail=1, dat_aligned[cur_ch] stays 0 -> NEXT_CH.
- SLIP:
  - dat_bitslip[cur_ch]=1 for one cycle.
  - slip_cnt++, tap=0, window registers cleared.
  - Then wait SETTLE cycles -> LOAD.
- CENTER_LD: one-cycle idelay_ld with the centre tap. The tap value stays on cnt_value[cur_ch] permanently. Set dat_aligned[cur_ch]=1 -> NEXT_CH.
- NEXT_CH:
  - If cur_ch == N_CH-1 -> DONE, with align_busy=0 and align_done=1.
  - Otherwise cur_ch++, tap=0, slip_cnt=0, window cleared -> LOAD.

Timing:
- Per-tap cost with a passing tap: 1 + SETTLE + JUDGE_LEN + 1 cycles.
- A failing tap exits JUDGE on the first mismatch.

Arithmetic rules:
- run_len, best_len: TAP_W+1 bits.
- Centre computation: TAP_W+1 bits, truncated to TAP_W bits (it cannot overflow).
- When two windows are equal in length, the first found wins (strict > compare).

Boundary and error conditions:
- A window ending at the top tap is closed by EVAL without any special case.
- If fco_aligned or ad_test_mode falls while align_busy=1:
  - abort to IDLE;
  - align_busy=0, align_fail=1, align_done=0;
  - all dat_aligned cleared;
  - cnt_value values are held.
- start while busy: ignored.
- reset_n low at any time: immediate return to reset values, including mid-pulse strobes.
- idelay_ld and dat_bitslip are never asserted together, and never on more than one lane at a time.

Test Plan:
1. N_CH=4. Every lane matches only at taps 8..20, slip 0, then start -> each cnt_value=14, dat_aligned=4'hF, align_done=1, align_fail=0, zero bitslip pulses.
2. Lane 2 correct only after 3 bitslips, window taps 5..15 -> exactly 3 dat_bitslip[2] pulses, cnt_value[2]=10, dat_aligned[2]=1.
3. Lane 0 passes at taps 2..4 and 10..25 -> best window 16 taps, cnt_value[0]=17 (not 3).
4. Lane 1 never matches -> 13 bitslip pulses, then dat_aligned[1]=0 and align_fail=1. Lanes 2..3 are still aligned and align_done=1.
5. Single-cycle corruption at tap 12 inside window 6..22 -> tap 12 fails. The window becomes 13..22 (10 taps) versus 6..11 (6 taps), so cnt_value=17.
6. ad_test_mode dropped during lane 1 JUDGE -> next cycle IDLE, align_fail=1, dat_aligned=0. A later reset_n pulse mid-scan clears all outputs asynchronously.
